pong_paddle_poll_ctrl: RTL and testbench



---
 rtl/pong_paddle_poll_ctrl_if.sv | 11 +
 rtl/pong_paddle_poll_ctrl.sv | 74 +++++++
 tb/tb_pong_paddle_poll_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pong_paddle_poll_ctrl_if.sv
// pong_paddle_poll_ctrl_if: shared Avalon-MM read path to the left/right paddle PIO slaves
interface pong_paddle_poll_ctrl_if;
   logic [1:0]  address;
   logic        cs_l;
   logic        cs_r;
   logic        read;
   logic        waitrequest;
   logic [31:0] readdata;
   modport master(output address, cs_l, cs_r, read, input waitrequest, readdata);
   modport slave(input address, cs_l, cs_r, read, output waitrequest, readdata);
endinterface

// File: rtl/pong_paddle_poll_ctrl.sv
// pong_paddle_poll_ctrl: frame-rate poller of two paddle PIOs with clamping and slew limiting
module pong_paddle_poll_ctrl #(
   parameter int TICK_DIV = 833333,
   parameter int Y_MAX    = 200,
   parameter int MAX_STEP = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   pong_paddle_poll_ctrl_if.master        avm,
   output logic [7:0]                     pos_l,
   output logic [7:0]                     pos_r,
   output logic                           pos_valid,
   output logic                           busy,
   output logic                           overrun
);
   localparam logic [7:0]  YM   = 8'(Y_MAX);
   localparam logic [7:0]  HALF = 8'(Y_MAX / 2);
   localparam logic [8:0]  MS   = 9'(MAX_STEP);
   localparam logic [23:0] LAST = 24'(TICK_DIV - 1);
   typedef enum logic [2:0] {IDLE, RD_L, LAT_L, RD_R, LAT_R, UPDATE} state_t;
   state_t      state, nxt;
   logic [23:0] cnt;
   logic [7:0]  raw_l;
   logic        tick;
   logic        unused_hi;
   function automatic logic [7:0] slew(input logic [7:0] raw, input logic [7:0] pos);
      logic [8:0] tgt, cur, d, st;
      tgt = {1'b0, (raw > YM) ? YM : raw};
      cur = {1'b0, pos};
      d   = (tgt > cur) ? tgt - cur : cur - tgt;
      st  = (d > MS) ? MS : d;
      return (tgt > cur) ? pos + st[7:0] : pos - st[7:0];
   endfunction
   assign tick          = enable && cnt == LAST;
   assign avm.address   = '0;
   assign avm.read      = state == RD_L || state == RD_R;
   assign avm.cs_l      = state == RD_L;
   assign avm.cs_r      = state == RD_R;
   assign busy          = state != IDLE;
   assign pos_valid     = state == UPDATE;
   assign unused_hi     = ^avm.readdata[31:8];
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         state   <= IDLE;
         raw_l   <= '0;
         pos_l   <= HALF;
         pos_r   <= HALF;
         overrun <= 1'b0;
      end else begin
         cnt   <= (!enable || tick) ? '0 : cnt + 24'd1;
         state <= nxt;
         if (state == LAT_L) raw_l <= avm.readdata[7:0];
         // positions land on the edge entering UPDATE so they change together with pos_valid
         if (state == LAT_R) begin
            pos_l <= slew(raw_l, pos_l);
            pos_r <= slew(avm.readdata[7:0], pos_r);
         end
         if (tick && state != IDLE) overrun <= 1'b1;
      end
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = tick ? RD_L : IDLE;
         RD_L:    nxt = avm.waitrequest ? RD_L : LAT_L;
         LAT_L:   nxt = RD_R;
         RD_R:    nxt = avm.waitrequest ? RD_R : LAT_R;
         LAT_R:   nxt = UPDATE;
         default: nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_pong_paddle_poll_ctrl.sv
// tb_pong_paddle_poll_ctrl: directed table-driven bench with two DUTs (TICK_DIV 10 and 4)
module tb_pong_paddle_poll_ctrl;
   logic       clk = 1'b0;
   logic       reset, enable, reset4, enable4;
   logic [7:0] pos_l, pos_r, pos_l4, pos_r4;
   logic       pos_valid, busy, overrun, pos_valid4, busy4, overrun4;
   logic [7:0] lval, rval, lval4, rval4;
   int         checks = 0, errors = 0;
   typedef struct {logic [7:0] l, r, el, er;} vec_t;
   vec_t v[17];
   always #5 clk = ~clk;
   pong_paddle_poll_ctrl_if bus();
   pong_paddle_poll_ctrl_if bus4();
   pong_paddle_poll_ctrl #(.TICK_DIV(10), .Y_MAX(200), .MAX_STEP(8)) dut (
      .clk(clk), .reset(reset), .enable(enable), .avm(bus),
      .pos_l(pos_l), .pos_r(pos_r), .pos_valid(pos_valid), .busy(busy), .overrun(overrun));
   pong_paddle_poll_ctrl #(.TICK_DIV(4), .Y_MAX(200), .MAX_STEP(8)) dut4 (
      .clk(clk), .reset(reset4), .enable(enable4), .avm(bus4),
      .pos_l(pos_l4), .pos_r(pos_r4), .pos_valid(pos_valid4), .busy(busy4), .overrun(overrun4));
   // slaves answer one cycle after an accepted read, with junk in the upper bits
   always @(posedge clk) if (bus.read && !bus.waitrequest) bus.readdata <= {24'hFFFFFF, bus.cs_l ? lval : rval};
   always @(posedge clk) if (bus4.read && !bus4.waitrequest) bus4.readdata <= {24'hFFFFFF, bus4.cs_l ? lval4 : rval4};
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic wait_cs_l(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = bus.cs_l;
      end
   endtask
   task automatic wait_valid(output int n);
      n = 0;
      for (int i = 1; i <= 60 && n == 0; i++) begin
         @(negedge clk);
         if (pos_valid) n = i;
      end
   endtask
   initial begin
      logic ok;
      int   n, cnt_rd;
      reset = 1; enable = 0; reset4 = 1; enable4 = 0;
      bus.waitrequest = 0; bus4.waitrequest = 1;
      lval = 8'd104; rval = 8'd90; lval4 = 8'd50; rval4 = 8'd150;
      v[0]  = '{8'd104, 8'd90, 8'd104, 8'd92};
      v[1]  = '{8'd255, 8'd0, 8'd112, 8'd84};
      for (int k = 0; k < 11; k++) v[2+k] = '{8'd255, 8'd0, 8'(120 + 8*k), (k == 10) ? 8'd0 : 8'(76 - 8*k)};
      v[13] = '{8'd255, 8'd0, 8'd200, 8'd0};
      v[14] = '{8'd197, 8'd3, 8'd197, 8'd3};
      v[15] = '{8'd0, 8'd255, 8'd189, 8'd11};
      v[16] = '{8'd189, 8'd11, 8'd189, 8'd11};
      repeat (3) @(negedge clk);
      chk("reset_pos_l", pos_l, 100);
      chk("reset_pos_r", pos_r, 100);
      chk("reset_flags", {pos_valid, busy, overrun}, 0);
      chk("reset_bus", {bus.read, bus.cs_l, bus.cs_r, bus.address}, 0);
      reset = 0; enable = 1;
      for (int i = 0; i < 17; i++) begin
         lval = v[i].l; rval = v[i].r;
         wait_cs_l(ok);
         chk($sformatf("rd_l_start[%0d]", i), ok, 1);
         wait_valid(n);
         chk($sformatf("latency[%0d]", i), n, 4);
         chk($sformatf("pos_l[%0d]", i), pos_l, v[i].el);
         chk($sformatf("pos_r[%0d]", i), pos_r, v[i].er);
         @(negedge clk);
         chk($sformatf("valid_pulse[%0d]", i), pos_valid, 0);
      end
      bus.waitrequest = 1; lval = 8'h32; rval = 8'd11;
      wait_cs_l(ok);
      chk("stall_start", ok, 1);
      chk("stall_bus0", {bus.read, bus.cs_l, bus.cs_r}, 3'b110);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk($sformatf("stall_bus%0d", k), {bus.read, bus.cs_l, bus.cs_r}, 3'b110);
      end
      bus.waitrequest = 0;
      wait_valid(n);
      chk("stall_latency", n, 4);
      chk("stall_pos_l", pos_l, 181);
      chk("stall_pos_r", pos_r, 11);
      lval = 8'd190; rval = 8'd20;
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = bus.cs_r;
      end
      chk("rd_r_seen", ok, 1);
      enable = 0;
      wait_valid(n);
      chk("disable_latency", n, 2);
      chk("disable_pos_l", pos_l, 189);
      chk("disable_pos_r", pos_r, 19);
      cnt_rd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.read || pos_valid) cnt_rd++;
      end
      chk("disabled_no_poll", cnt_rd, 0);
      enable = 1; lval = 8'd0; rval = 8'd0;
      wait_cs_l(ok);
      chk("reset_test_start", ok, 1);
      @(negedge clk);
      chk("in_lat_l", {busy, bus.read}, 2'b10);
      reset = 1;
      @(negedge clk);
      chk("midreset_pos_l", pos_l, 100);
      chk("midreset_pos_r", pos_r, 100);
      chk("midreset_flags", {pos_valid, busy, bus.read, bus.cs_l, bus.cs_r}, 0);
      cnt_rd = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (pos_valid) cnt_rd++;
      end
      chk("midreset_no_valid", cnt_rd, 0);
      reset = 0;
      reset4 = 0; enable4 = 1;
      cnt_rd = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (pos_valid4) cnt_rd++;
      end
      chk("ovr_no_valid", cnt_rd, 0);
      chk("ovr_set", overrun4, 1);
      chk("ovr_stalled", {busy4, bus4.read, bus4.cs_l, bus4.cs_r}, 4'b1110);
      bus4.waitrequest = 0;
      n = 0;
      for (int i = 1; i <= 60 && n == 0; i++) begin
         @(negedge clk);
         if (pos_valid4) n = i;
      end
      chk("ovr_poll_done", n != 0, 1);
      chk("ovr_pos_l", pos_l4, 92);
      chk("ovr_pos_r", pos_r4, 108);
      @(negedge clk);
      chk("ovr_idle_after", busy4, 0);
      chk("ovr_sticky", overrun4, 1);
      reset4 = 1;
      @(negedge clk);
      chk("ovr_cleared", overrun4, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
